// File: rtl/divide_sequencer_pkg.sv
// Shared types for the divide sequencer: CPU data word, FSM states and divider bus payloads.

package cpu_core_params;
    localparam int unsigned CPU_DATA_WIDTH = 32;
    typedef logic [CPU_DATA_WIDTH-1:0] cpu_data_t;
endpackage

package divide_params;
    import cpu_core_params::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } divide_state_t;

    typedef struct packed {
        logic      valid;
        logic      is_signed;
        cpu_data_t dividend;
        cpu_data_t divisor;
    } divide_operand_bus_t;

    typedef struct packed {
        logic      valid;
        cpu_data_t quotient;
        cpu_data_t remainder;
    } divide_result_bus_t;
endpackage

// File: rtl/divide_sequencer.sv
// Sequences one DIV/DIVU at a time through the shared divider core, holding the
// result for EX, draining results of flushed operations, and flagging a stuck core.

module divide_sequencer
    import divide_params::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned COUNT_WIDTH    = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ex_valid,
    input  logic                  divide_request,
    input  logic                  divide_signed,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  io_allow_in,
    input  logic                  flush,
    output logic                  operand_valid,
    input  logic                  operand_ready,
    output logic                  operand_signed,
    output logic [DATA_WIDTH-1:0] operand_dividend,
    output logic [DATA_WIDTH-1:0] operand_divisor,
    input  logic                  result_valid,
    input  logic [DATA_WIDTH-1:0] result_quotient,
    input  logic [DATA_WIDTH-1:0] result_remainder,
    output logic                  ex_stall,
    output logic                  divide_result_valid,
    output logic [DATA_WIDTH-1:0] divide_result,
    output logic [DATA_WIDTH-1:0] divide_remain,
    output logic                  timeout_error
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(TIMEOUT_CYCLES);

    divide_state_t          state;
    logic                   cancelled;
    logic [COUNT_WIDTH-1:0] counter;
    logic                   start_c;

    assign start_c = ex_valid & divide_request & ~flush;

    // A divide in EX stalls until its own (non-cancelled) result is presented.
    assign ex_stall = ex_valid & divide_request & ~((state == DONE) & ~cancelled);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            cancelled           <= 1'b0;
            counter             <= '0;
            operand_valid       <= 1'b0;
            operand_signed      <= 1'b0;
            operand_dividend    <= '0;
            operand_divisor     <= '0;
            divide_result_valid <= 1'b0;
            divide_result       <= '0;
            divide_remain       <= '0;
            timeout_error       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cancelled <= 1'b0;
                    if (start_c) begin
                        operand_valid    <= 1'b1;
                        operand_signed   <= divide_signed;
                        operand_dividend <= dividend;
                        operand_divisor  <= divisor;
                        state            <= ISSUE;
                    end
                end

                // Operands stay valid through a flush; the handshake must complete.
                ISSUE: begin
                    if (flush) begin
                        cancelled <= 1'b1;
                    end
                    if (operand_ready) begin
                        operand_valid <= 1'b0;
                        counter       <= '0;
                        state         <= WAIT;
                    end
                end

                WAIT: begin
                    if (counter != COUNT_MAX) begin
                        counter <= counter + COUNT_WIDTH'(1);
                    end else begin
                        timeout_error <= 1'b1;
                    end
                    if (result_valid) begin
                        if (cancelled | flush) begin
                            cancelled <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            divide_result       <= result_quotient;
                            divide_remain       <= result_remainder;
                            divide_result_valid <= 1'b1;
                            state               <= DONE;
                        end
                    end else if (flush) begin
                        cancelled <= 1'b1;
                    end
                end

                DONE: begin
                    if (io_allow_in | flush) begin
                        divide_result_valid <= 1'b0;
                        cancelled           <= 1'b0;
                        state               <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divide_sequencer.sv
// Randomized scoreboard bench for divide_sequencer with a behavioural divider core model.

module tb_divide_sequencer;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         ex_valid, divide_request, divide_signed;
    logic [W-1:0] dividend, divisor;
    logic         io_allow_in, flush;
    logic         operand_valid, operand_ready, operand_signed;
    logic [W-1:0] operand_dividend, operand_divisor;
    logic         result_valid;
    logic [W-1:0] result_quotient, result_remainder;
    logic         ex_stall, divide_result_valid;
    logic [W-1:0] divide_result, divide_remain;
    logic         timeout_error;

    divide_sequencer #(.DATA_WIDTH(W), .TIMEOUT_CYCLES(64)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .ex_valid            (ex_valid),
        .divide_request      (divide_request),
        .divide_signed       (divide_signed),
        .dividend            (dividend),
        .divisor             (divisor),
        .io_allow_in         (io_allow_in),
        .flush               (flush),
        .operand_valid       (operand_valid),
        .operand_ready       (operand_ready),
        .operand_signed      (operand_signed),
        .operand_dividend    (operand_dividend),
        .operand_divisor     (operand_divisor),
        .result_valid        (result_valid),
        .result_quotient     (result_quotient),
        .result_remainder    (result_remainder),
        .ex_stall            (ex_stall),
        .divide_result_valid (divide_result_valid),
        .divide_result       (divide_result),
        .divide_remain       (divide_remain),
        .timeout_error       (timeout_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

    res_t want_q[$];
    int   total = 0;
    int   bad = 0;

    // Divider core knobs set by the stimulus.
    int   core_latency = 4;
    int   ready_delay = 0;
    bit   ready_random = 1'b0;
    bit   core_mute = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // MIPS DIV/DIVU: quotient truncates toward zero, remainder takes dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Divider core: handshake, fixed latency per op, spurious pulses when nothing is outstanding.
    initial begin : core
        int          cnt;
        int          ov_cycles;
        bit          outstanding, hs, prev_ov, prev_hs;
        logic [63:0] core_res;
        logic [31:0] prev_a, prev_b;
        logic        prev_s;
        cnt = 0; ov_cycles = 0; outstanding = 0; prev_ov = 0; prev_hs = 0;
        core_res = '0; prev_a = '0; prev_b = '0; prev_s = 1'b0;
        operand_ready = 1'b0; result_valid = 1'b0;
        result_quotient = '0; result_remainder = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                cnt = 0; ov_cycles = 0; outstanding = 0; prev_ov = 0; prev_hs = 0;
            end else begin
                if (prev_ov && !prev_hs) begin
                    chk("operand_valid_held", 64'(operand_valid), 64'(1));
                    chk("operand_dividend_stable", 64'(operand_dividend), 64'(prev_a));
                    chk("operand_divisor_stable", 64'(operand_divisor), 64'(prev_b));
                    chk("operand_signed_stable", 64'(operand_signed), 64'(prev_s));
                end
                hs = operand_valid && operand_ready;
                if (hs) begin
                    outstanding = 1'b1;
                    ov_cycles = 0;
                    if (!core_mute) begin
                        cnt = core_latency;
                        core_res = ref_div(operand_dividend, operand_divisor, operand_signed);
                    end
                end else if (operand_valid) begin
                    ov_cycles++;
                end
                prev_ov = operand_valid; prev_hs = hs;
                prev_a = operand_dividend; prev_b = operand_divisor; prev_s = operand_signed;
            end
            @(posedge clock); #1;
            result_valid = 1'b0;
            result_quotient = $urandom;
            result_remainder = $urandom;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    result_valid = 1'b1;
                    {result_quotient, result_remainder} = core_res;
                    outstanding = 1'b0;
                end
            end else if (!outstanding && ($urandom % 6 == 0)) begin
                result_valid = 1'b1;
            end
            operand_ready = ready_random ? 1'($urandom % 2) : (ov_cycles >= ready_delay);
        end
    end

    // Monitor: results are consumed when IO takes them without a flush.
    initial begin : monitor
        logic        pv, pacc;
        logic [31:0] pq, pr;
        res_t        e;
        pv = 1'b0; pacc = 1'b0; pq = '0; pr = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                pv = 1'b0; pacc = 1'b0;
            end else begin
                if (ex_valid && divide_request)
                    chk("ex_stall_div", 64'(ex_stall), 64'(!divide_result_valid));
                else
                    chk("ex_stall_nondiv", 64'(ex_stall), 64'(0));
                if (pv && pacc) begin
                    chk("result_pulse_drop", 64'(divide_result_valid), 64'(0));
                end else if (pv) begin
                    chk("result_valid_held", 64'(divide_result_valid), 64'(1));
                    chk("quotient_held", 64'(divide_result), 64'(pq));
                    chk("remainder_held", 64'(divide_remain), 64'(pr));
                end
                if (divide_result_valid && io_allow_in && !flush) begin
                    if (want_q.size() == 0) begin
                        chk("unexpected_result", 64'(1), 64'(0));
                    end else begin
                        e = want_q.pop_front();
                        chk("quotient", 64'(divide_result), 64'(e.q));
                        chk("remainder", 64'(divide_remain), 64'(e.r));
                    end
                end
                pv = divide_result_valid; pacc = io_allow_in || flush;
                pq = divide_result; pr = divide_remain;
            end
        end
    end

    task automatic apply_reset();
        reset_n = 1'b0;
        ex_valid = 1'b0; divide_request = 1'b0; flush = 1'b0; io_allow_in = 1'b0;
        want_q.delete();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    // Present one divide to EX and hold it until IO takes it or it is flushed at cycle flush_at.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er,
                          input int flush_at, input int io_hold, output int stalls);
        int   cyc, hold;
        bit   fin;
        res_t e;
        cyc = 0; hold = 0; fin = 1'b0; stalls = 0;
        ex_valid = 1'b1; divide_request = 1'b1;
        dividend = a; divisor = b; divide_signed = s;
        e.q = eq; e.r = er;
        want_q.push_back(e);
        while (!fin) begin
            flush = (cyc == flush_at);
            io_allow_in = (hold >= io_hold);
            if (flush && want_q.size() > 0) want_q.delete(want_q.size() - 1);
            @(negedge clock);
            if (ex_stall) stalls++;
            if (flush) fin = 1'b1;
            else if (!ex_stall && io_allow_in) fin = 1'b1;
            else if (!ex_stall) hold++;
            cyc++;
            @(posedge clock); #1;
            if (!fin && cyc > 300) begin
                chk("divide_completes", 64'(0), 64'(1));
                apply_reset();
                fin = 1'b1;
            end
        end
        ex_valid = 1'b0; divide_request = 1'b0; flush = 1'b0;
        io_allow_in = 1'($urandom % 2);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            ex_valid = 1'($urandom % 2); divide_request = 1'b0;
            io_allow_in = 1'($urandom % 2); flush = 1'($urandom % 5 == 0);
            @(posedge clock); #1;
        end
        flush = 1'b0; ex_valid = 1'b0;
    endtask

    initial begin : stim
        int          stalls;
        logic [31:0] a, b;
        logic        s;
        logic [63:0] qr;
        int          fat;
        ex_valid = 1'b0; divide_request = 1'b0; divide_signed = 1'b0;
        dividend = '0; divisor = '0; io_allow_in = 1'b0; flush = 1'b0;

        #12;
        chk("reset_operand_valid", 64'(operand_valid), 64'(0));
        chk("reset_result_valid", 64'(divide_result_valid), 64'(0));
        chk("reset_result", 64'(divide_result), 64'(0));
        chk("reset_remain", 64'(divide_remain), 64'(0));
        chk("reset_timeout", 64'(timeout_error), 64'(0));
        chk("reset_ex_stall", 64'(ex_stall), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Basic signed divide, core answers 8 cycles after the handshake.
        core_latency = 8; ready_delay = 0; ready_random = 1'b0;
        do_div(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, -1, 0, stalls);
        chk("basic_stall_cycles", 64'(stalls), 64'(10));
        gap(2);

        // Backpressure on the operand channel and on IO.
        core_latency = 6; ready_delay = 5;
        do_div(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, -1, 3, stalls);
        chk("backpressure_stall_cycles", 64'(stalls), 64'(1 + 1 + 5 + 6));
        gap(2);

        // Flush while waiting; the next divide arrives during the drain.
        core_latency = 10; ready_delay = 0;
        do_div(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 3, 0, stalls);
        core_latency = 4;
        do_div(32'hFFFF_FFFF, 32'd2, 1'b0, 32'h7FFF_FFFF, 32'd1, -1, 0, stalls);
        gap(2);

        // Flush in the same cycle as the operand handshake.
        core_latency = 5;
        do_div(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1, 0, stalls);
        do_div(32'd51, 32'd5, 1'b0, 32'd10, 32'd1, -1, 0, stalls);
        gap(2);

        // Request with flush in IDLE never issues.
        ex_valid = 1'b1; divide_request = 1'b1; flush = 1'b1;
        dividend = 32'd9; divisor = 32'd3;
        repeat (3) begin
            @(negedge clock);
            chk("no_issue_on_flush", 64'(operand_valid), 64'(0));
            @(posedge clock); #1;
        end
        ex_valid = 1'b0; divide_request = 1'b0; flush = 1'b0;
        @(negedge clock);
        chk("no_issue_after_flush", 64'(operand_valid), 64'(0));
        @(posedge clock); #1;

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom;
            if ($urandom % 2) b = b >> $urandom_range(0, 31);
            if (b == 0) b = 32'd1;
            s = 1'($urandom % 2);
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            qr = ref_div(a, b, s);
            fat = ($urandom % 4 == 0) ? int'($urandom_range(0, 20)) : -1;
            core_latency = int'($urandom_range(1, 12));
            ready_delay = int'($urandom_range(0, 3));
            ready_random = ($urandom % 3 == 0);
            do_div(a, b, s, qr[63:32], qr[31:0], fat, int'($urandom_range(0, 3)), stalls);
            gap(int'($urandom_range(0, 2)));
        end
        ready_random = 1'b0; ready_delay = 0;
        gap(30);
        chk("no_timeout_in_normal_traffic", 64'(timeout_error), 64'(0));

        // Core never answers: watchdog fires and stays set until reset.
        core_mute = 1'b1;
        ex_valid = 1'b1; divide_request = 1'b1; divide_signed = 1'b0;
        dividend = 32'd77; divisor = 32'd7; io_allow_in = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (c == 60) chk("timeout_not_yet", 64'(timeout_error), 64'(0));
            if (c == 80) chk("timeout_set", 64'(timeout_error), 64'(1));
            @(posedge clock); #1;
        end
        flush = 1'b1;
        @(posedge clock); #1;
        ex_valid = 1'b0; divide_request = 1'b0; flush = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("timeout_sticky", 64'(timeout_error), 64'(1));
        @(posedge clock); #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset_timeout", 64'(timeout_error), 64'(0));
        chk("async_reset_operand_valid", 64'(operand_valid), 64'(0));
        chk("async_reset_operand_dividend", 64'(operand_dividend), 64'(0));
        chk("async_reset_operand_divisor", 64'(operand_divisor), 64'(0));
        chk("async_reset_result_valid", 64'(divide_result_valid), 64'(0));
        chk("async_reset_result", 64'(divide_result), 64'(0));
        chk("async_reset_remain", 64'(divide_remain), 64'(0));
        core_mute = 1'b0;
        apply_reset();

        // Normal operation resumes after reset.
        core_latency = 3;
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1, 0, stalls);
        gap(5);
        chk("scoreboard_empty", 64'(want_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divide_sequencer.md
Name: divide_sequencer

Overview:
- Sequences the shared multi-cycle divider on behalf of the EX stage.
- Accepts DIV/DIVU from the EX instruction and issues operands to the divider core over a valid/ready channel.
- Waits for the result, holds quotient/remainder stable and stalls EX until the IO stage takes the instruction.
- Handles exception/ERET flush mid-operation by draining and discarding the in-flight result; flags a watchdog timeout.

Parameters:
DATA_WIDTH, 32, operand/result width (cpu_data_t width)
TIMEOUT_CYCLES, 64, max cycles in WAIT before timeout_error sets
COUNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), watchdog counter width

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX holds a valid instruction
divide_request  in  1  EX instruction is DIV/DIVU
divide_signed  in  1  1 = DIV, 0 = DIVU
dividend  in  DATA_WIDTH  rs value
divisor  in  DATA_WIDTH  rt value
io_allow_in  in  1  IO stage accepts EX output this cycle
flush  in  1  exception/eret flush; kills EX instruction
operand_valid  out  1  operands presented to divider core
operand_ready  in  1  divider core accepts operands
operand_signed  out  1  registered divide_signed
operand_dividend  out  DATA_WIDTH  registered dividend
operand_divisor  out  DATA_WIDTH  registered divisor
result_valid  in  1  one-cycle pulse: core result ready
result_quotient  in  DATA_WIDTH  core quotient
result_remainder  in  DATA_WIDTH  core remainder
ex_stall  out  1  EX must not advance (combinational)
divide_result_valid  out  1  quotient/remainder valid for EX instruction
divide_result  out  DATA_WIDTH  held quotient (to LO)
divide_remain  out  DATA_WIDTH  held remainder (to HI)
timeout_error  out  1  sticky watchdog flag

Behaviour:
- Reset (async, reset_n low): state IDLE, cancelled=0, counter=0. All outputs 0 except ex_stall, which follows its equation.
- start = ex_valid & divide_request & ~flush.
- IDLE:
  - start -> latch operands and signed, operand_valid=1 next cycle, go ISSUE.
  - Request never issues while flush is high.
- ISSUE:
  - operand_valid=1; operands held stable until operand_ready=1 (no drop of valid, even on flush).
  - On operand_ready -> WAIT, operand_valid=0 next cycle.
- WAIT:
  - counter increments each cycle, saturating at TIMEOUT_CYCLES.
  - counter==TIMEOUT_CYCLES sets timeout_error; it stays set until reset.
  - On result_valid with cancelled=0 -> latch quotient/remainder, divide_result_valid=1, go DONE.
  - On result_valid with cancelled=1 -> discard, go IDLE, clear cancelled.
- DONE:
  - Outputs held.
  - io_allow_in=1 -> IDLE, divide_result_valid=0 next cycle.
  - flush -> IDLE, result dropped.
- cancelled:
  - Set by flush while in ISSUE or WAIT.
  - Cleared on return to IDLE.
- ex_stall = ex_valid & divide_request & ~(state==DONE & ~cancelled).
  - Covers a new divide arriving during a drain: it stalls until IDLE, then issues.
  - Non-divide instructions never stall.
- Latency: issue-to-DONE = 1 (ISSUE) + operand handshake wait + core latency + 1 register.
- Simultaneous events:
  - flush & operand_ready in ISSUE -> WAIT with cancelled=1.
  - flush & result_valid in WAIT -> discard, IDLE.
  - io_allow_in & flush in DONE -> IDLE.
  - result_valid in IDLE/ISSUE/DONE is ignored.
- One operation in flight maximum. Counter resets on entry to WAIT.

Decomposition:
- Shared package divide_params:
  - divide_state_t enum {IDLE, ISSUE, WAIT, DONE}.
  - divide_operand_bus_t (valid, signed, dividend, divisor).
  - divide_result_bus_t (valid, quotient, remainder).
  - Reuses cpu_data_t from cpu_core_params.
- Single module. The watchdog counter is small and stays inline; no sub-module.

Test Plan:
- Basic DIV:
  - Stimulus: dividend=100, divisor=7, signed=1; operand_ready same cycle; result_valid 8 cycles later with q=14, r=2; io_allow_in=1.
  - Response: ex_stall=1 until DONE; divide_result=14, divide_remain=2, divide_result_valid for exactly 1 cycle; IDLE next.
- Backpressure:
  - Stimulus: operand_ready low for 5 cycles; io_allow_in low 3 cycles in DONE.
  - Response: operands stable while waiting; result held stable; ex_stall drops only in DONE.
- Flush in WAIT:
  - Stimulus: flush 3 cycles after issue; result_valid later.
  - Response: no divide_result_valid; state IDLE after result_valid.
  - Follow-up: a new DIVU (0xFFFFFFFF / 2) arriving during the drain stalls, then issues, giving q=0x7FFFFFFF, r=1.
- Flush with operand_ready in the same cycle:
  - Response: handshake completes; the result is discarded.
- Flush with request in IDLE:
  - Response: operand_valid stays 0.
- Timeout:
  - Stimulus: no result_valid for 64 cycles in WAIT.
  - Response: timeout_error=1, sticky; it clears only on reset_n=0, and that reset clears all outputs asynchronously.
